// File: rtl/const_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : const_div_pkg
//  Description : Shared helpers for the constant-divisor divmod pipeline.
//                num_stages() gives the number of radix-2^K digit stages,
//                rem_width() the remainder width, params_ok() the legal
//                parameter range used for elaboration checks.
//  Revision    : 1.0 - initial release
// ============================================================================
package const_div_pkg;

    localparam int c_K_MIN = 1;
    localparam int c_K_MAX = 8;
    localparam int c_D_MIN = 2;

    // ceil(w / k): one stage per K-bit digit of the zero-extended operand.
    function automatic int num_stages(input int w, input int k);
        return (w + k - 1) / k;
    endfunction

    // A remainder is always < d, so $clog2(d) bits hold it.
    function automatic int rem_width(input int d);
        return $clog2(d);
    endfunction

    // Divisor must fit in the operand; for w >= 31 every positive int fits.
    function automatic bit params_ok(input int w, input int d, input int k, input int tagw);
        bit ok;
        ok = (w >= 2) && (tagw >= 1) && (k >= c_K_MIN) && (k <= c_K_MAX) && (d >= c_D_MIN);
        if (w < 31) begin
            ok = ok && (d < (1 << w));
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/const_divmod_digit.sv
`default_nettype none
// ============================================================================
//  Module      : const_divmod_digit
//  Description : One combinational radix-2^K long-division step by the
//                constant D. Forms t = r*2^K + digit and returns
//                r_next = t mod D and q_digit = t / D.
//  Ports       : r       in  running remainder (< D)
//                digit   in  next K-bit dividend digit
//                r_next  out updated remainder
//                q_digit out quotient digit (always < 2^K because r < D)
//  Revision    : 1.0 - initial release
// ============================================================================
module const_divmod_digit
    import const_div_pkg::*;
#(
    parameter int D = 23,
    parameter int K = 4
) (
    input  logic [rem_width(D)-1:0] r,
    input  logic [K-1:0]            digit,
    output logic [rem_width(D)-1:0] r_next,
    output logic [K-1:0]            q_digit
);

    localparam int c_RW = rem_width(D);
    localparam int c_TW = c_RW + K;
    localparam logic [c_TW-1:0] c_DIV = c_TW'(D);

    logic [c_TW-1:0] w_partial;

    // Concatenation is r*2^K + digit; the divisor is constant so synthesis
    // reduces the divide/modulo to a small lookup of c_TW input bits.
    assign w_partial = {r, digit};
    assign r_next    = c_RW'(w_partial % c_DIV);
    assign q_digit   = K'(w_partial / c_DIV);

endmodule
`default_nettype wire

// File: rtl/const_divmod_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : const_divmod_pipe
//  Description : Pipelined quotient/remainder of a W-bit unsigned operand by
//                the compile-time constant D. One radix-2^K digit retired per
//                stage, MSB first; S = ceil(W/K) digit stages follow an input
//                register, so S+1 operands can be in flight. Valid/ready on
//                both sides with a single global advance (full backpressure).
//  Ports       : clk, rst            clock, synchronous active-high reset
//                in_valid/in_ready   operand handshake
//                in_x, in_tag        dividend and user tag
//                out_valid/out_ready result handshake
//                out_q, out_r        floor(x/D), x mod D
//                out_tag             tag of the operand this result belongs to
//  Revision    : 1.0 - initial release
// ============================================================================
module const_divmod_pipe
    import const_div_pkg::*;
#(
    parameter int W    = 16,
    parameter int D    = 23,
    parameter int K    = 4,
    parameter int TAGW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_x,
    input  logic [TAGW-1:0]         in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_q,
    output logic [rem_width(D)-1:0] out_r,
    output logic [TAGW-1:0]         out_tag
);

    localparam int c_S  = num_stages(W, K);
    localparam int c_P  = c_S * K;
    localparam int c_RW = rem_width(D);

    if (!params_ok(W, D, K, TAGW)) begin : g_param_check
        $error("const_divmod_pipe: illegal parameters W=%0d D=%0d K=%0d TAGW=%0d", W, D, K, TAGW);
    end

    // Stage i holds a c_P-bit accumulator: the still-unconsumed dividend
    // digits in its upper part and the quotient digits produced so far in
    // its lower part. Each stage shifts one digit out at the top and one
    // quotient digit in at the bottom, so after c_S stages it is the quotient.
    logic                w_advance;
    logic                r_vld_q    [0:c_S];
    logic                w_vld_d    [0:c_S];
    logic [c_P-1:0]      r_acc_q    [0:c_S];
    logic [c_P-1:0]      w_acc_d    [0:c_S];
    logic [TAGW-1:0]     r_tag_q    [0:c_S];
    logic [TAGW-1:0]     w_tag_d    [0:c_S];
    logic [c_RW-1:0]     r_rem_q    [1:c_S];
    logic [c_RW-1:0]     w_rem_d    [1:c_S];
    logic [c_RW-1:0]     w_rem_in   [0:c_S-1];
    logic [c_RW-1:0]     w_rem_next [0:c_S-1];
    logic [K-1:0]        w_q_digit  [0:c_S-1];

    // The whole pipe moves together; a full output stage that is not being
    // popped freezes every stage, including the input register.
    assign w_advance = ~r_vld_q[c_S] | out_ready;
    assign in_ready  = w_advance;

    for (genvar i = 0; i < c_S; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign w_rem_in[i] = '0;
        end else begin : g_rest
            assign w_rem_in[i] = r_rem_q[i];
        end

        const_divmod_digit #(
            .D (D),
            .K (K)
        ) u_digit (
            .r       (w_rem_in[i]),
            .digit   (r_acc_q[i][c_P-1 -: K]),
            .r_next  (w_rem_next[i]),
            .q_digit (w_q_digit[i])
        );
    end

    always_comb begin
        // Operand zero-extended to c_P bits so digit 0 is the top K bits.
        w_vld_d[0] = in_valid;
        w_acc_d[0] = c_P'(in_x);
        w_tag_d[0] = in_tag;
        for (int i = 1; i <= c_S; i++) begin
            w_vld_d[i] = r_vld_q[i-1];
            w_acc_d[i] = (r_acc_q[i-1] << K) | c_P'(w_q_digit[i-1]);
            w_rem_d[i] = w_rem_next[i-1];
            w_tag_d[i] = r_tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= c_S; i++) begin
                r_vld_q[i] <= 1'b0;
                r_acc_q[i] <= '0;
                r_tag_q[i] <= '0;
            end
            for (int i = 1; i <= c_S; i++) begin
                r_rem_q[i] <= '0;
            end
        end else if (w_advance) begin
            for (int i = 0; i <= c_S; i++) begin
                r_vld_q[i] <= w_vld_d[i];
                r_acc_q[i] <= w_acc_d[i];
                r_tag_q[i] <= w_tag_d[i];
            end
            for (int i = 1; i <= c_S; i++) begin
                r_rem_q[i] <= w_rem_d[i];
            end
        end
    end

    // The top c_P-W quotient bits are always zero and are dropped.
    assign out_valid = r_vld_q[c_S];
    assign out_q     = W'(r_acc_q[c_S]);
    assign out_r     = r_rem_q[c_S];
    assign out_tag   = r_tag_q[c_S];

endmodule
`default_nettype wire

// File: tb/tb_const_divmod_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_const_divmod_pipe
//  Description : Self-checking bench for const_divmod_pipe. Five parameter
//                sets run side by side; each has a driver that pushes the
//                expected {q, r, tag} into a queue on acceptance and a
//                monitor that pops and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_const_divmod_pipe;

    localparam int NCFG = 5;
    localparam int TW   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic int cfg_w(input int c);
        case (c)
            1:       return 13;
            4:       return 12;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_d(input int c);
        case (c)
            1:       return 7;
            2:       return 3;
            3:       return 10;
            4:       return 255;
            default: return 23;
        endcase
    endfunction

    function automatic int cfg_k(input int c);
        case (c)
            2:       return 2;
            3:       return 5;
            4:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_n(input int c);
        return (c == 0) ? 4000 : 1500;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int W  = cfg_w(c);
        localparam int D  = cfg_d(c);
        localparam int K  = cfg_k(c);
        localparam int RW = $clog2(D);
        localparam int S  = (W + K - 1) / K;

        logic          rst       = 1'b1;
        logic          in_valid  = 1'b0;
        logic          in_ready;
        logic [W-1:0]  in_x      = '0;
        logic [TW-1:0] in_tag    = '0;
        logic          out_valid;
        logic          out_ready = 1'b0;
        logic [W-1:0]  out_q;
        logic [RW-1:0] out_r;
        logic [TW-1:0] out_tag;

        int            mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random
        bit            done = 1'b0;
        logic [TW-1:0] seq  = '0;

        logic [W-1:0]  eq_q [$];
        logic [RW-1:0] er_q [$];
        logic [TW-1:0] et_q [$];

        bit            held = 1'b0;
        logic [W-1:0]  held_q;
        logic [RW-1:0] held_r;
        logic [TW-1:0] held_t;

        const_divmod_pipe #(
            .W    (W),
            .D    (D),
            .K    (K),
            .TAGW (TW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_x      (in_x),
            .in_tag    (in_tag),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_q     (out_q),
            .out_r     (out_r),
            .out_tag   (out_tag)
        );

        // Reference: plain integer division.
        task automatic model(input logic [W-1:0] x, output logic [W-1:0] eq, output logic [RW-1:0] er);
            int xi;
            xi = int'(x);
            eq = W'(xi / D);
            er = RW'(xi % D);
        endtask

        function automatic logic [W-1:0] pick();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return W'(D - 1);
                3:       return W'(D);
                4:       return W'((1 << W) - 1 - $urandom_range(0, 3));
                default: return W'($urandom);
            endcase
        endfunction

        task automatic push_exp(input logic [W-1:0] eq, input logic [RW-1:0] er);
            eq_q.push_back(eq);
            er_q.push_back(er);
            et_q.push_back(seq);
            seq++;
        endtask

        // Called at a falling edge; returns at the next falling edge.
        task automatic drive_one(input logic [W-1:0] x, input logic [W-1:0] eq,
                                 input logic [RW-1:0] er, output bit acc);
            in_valid = 1'b1;
            in_x     = x;
            in_tag   = seq;
            #2;
            acc = in_ready;
            if (acc) push_exp(eq, er);
            @(negedge clk);
        endtask

        task automatic send(input logic [W-1:0] x, input logic [W-1:0] eq, input logic [RW-1:0] er);
            bit acc;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) drive_one(x, eq, er, acc);
            in_valid = 1'b0;
            chk("send_accept", acc, 1);
        endtask

        task automatic wait_empty();
            int t;
            t = 0;
            while (eq_q.size() != 0 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            repeat (S + 2) @(negedge clk);
            chk("drain", eq_q.size(), 0);
        endtask

        task automatic do_reset();
            rst      = 1'b1;
            in_valid = 1'b0;
            eq_q.delete();
            er_q.delete();
            et_q.delete();
            seq = '0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            chk("reset_valid", out_valid, 0);
            chk("reset_q", out_q, 0);
            chk("reset_r", out_r, 0);
            chk("reset_tag", out_tag, 0);
        endtask

        task automatic random_phase(input int n);
            int            sent;
            int            cyc;
            bit            acc;
            logic [W-1:0]  x;
            logic [W-1:0]  eq;
            logic [RW-1:0] er;
            mode = 2;
            sent = 0;
            cyc  = 0;
            while (sent < n && cyc < 40 * n) begin
                if ($urandom_range(0, 9) < 3) begin
                    in_valid = 1'b0;
                    in_x     = W'($urandom);
                    @(negedge clk);
                end else begin
                    x = pick();
                    model(x, eq, er);
                    drive_one(x, eq, er, acc);
                    if (acc) sent++;
                end
                cyc++;
            end
            in_valid = 1'b0;
            chk("rand_sent", sent, n);
            mode = 0;
            wait_empty();
        endtask

        // Monitor: drives out_ready, checks AXI-style hold and pops the scoreboard.
        initial begin
            forever begin
                @(negedge clk);
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = 1'b0;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                #1;
                if (rst) begin
                    held = 1'b0;
                end else begin
                    if (held) begin
                        chk("hold_valid", out_valid, 1);
                        chk("hold_q", out_q, held_q);
                        chk("hold_r", out_r, held_r);
                        chk("hold_tag", out_tag, held_t);
                    end
                    if (out_valid && out_ready) begin
                        if (eq_q.size() == 0) begin
                            chk("no_pending_result", out_valid, 0);
                        end else begin
                            chk("out_q", out_q, eq_q.pop_front());
                            chk("out_r", out_r, er_q.pop_front());
                            chk("out_tag", out_tag, et_q.pop_front());
                        end
                    end
                    held   = out_valid && !out_ready;
                    held_q = out_q;
                    held_r = out_r;
                    held_t = out_tag;
                end
            end
        end

        if (c == 0) begin : g_drv_main
            initial begin
                int            lat;
                int            nacc;
                int            nv;
                int            first;
                int            last;
                bit            acc;
                logic [W-1:0]  x;
                logic [W-1:0]  eq;
                logic [RW-1:0] er;

                do_reset();
                mode = 0;

                // Directed values and latency from an empty pipe.
                send(16'd23, 16'd1, 5'd0);
                lat = 0;
                while (!out_valid && lat < 30) begin
                    @(negedge clk);
                    lat++;
                end
                chk("latency", lat, S);
                send(16'd0, 16'd0, 5'd0);
                send(16'd22, 16'd0, 5'd22);
                send(16'd65535, 16'd2849, 5'd8);
                wait_empty();

                // Back-to-back: 20 operands, 20 consecutive results.
                nacc = 0; nv = 0; first = -1; last = -1;
                for (int k = 0; k < 40; k++) begin
                    if (k < 20) begin
                        x        = W'($urandom);
                        in_valid = 1'b1;
                        in_x     = x;
                        in_tag   = seq;
                    end else begin
                        in_valid = 1'b0;
                    end
                    #2;
                    if (k < 20 && in_ready) begin
                        model(x, eq, er);
                        push_exp(eq, er);
                        nacc++;
                    end
                    if (out_valid) begin
                        nv++;
                        if (first < 0) first = k;
                        last = k;
                    end
                    @(negedge clk);
                end
                chk("b2b_accepts", nacc, 20);
                chk("b2b_results", nv, 20);
                chk("b2b_run_length", last - first + 1, 20);
                wait_empty();

                // Backpressure: consumer stalled for 10 cycles.
                mode = 1;
                @(negedge clk);
                nacc = 0;
                for (int k = 0; k < 10; k++) begin
                    x        = W'($urandom);
                    in_valid = 1'b1;
                    in_x     = x;
                    in_tag   = seq;
                    #2;
                    if (in_ready) begin
                        model(x, eq, er);
                        push_exp(eq, er);
                        nacc++;
                    end
                    @(negedge clk);
                end
                chk("bp_accepts", nacc, S + 1);
                #2;
                chk("bp_in_ready", in_ready, 0);
                in_valid = 1'b0;
                mode = 0;
                wait_empty();

                // Reset with three operands in flight: none may emerge.
                nacc = 0;
                for (int k = 0; k < 3; k++) begin
                    x = W'($urandom);
                    model(x, eq, er);
                    drive_one(x, eq, er, acc);
                    if (acc) nacc++;
                end
                chk("midrst_accepts", nacc, 3);
                in_valid = 1'b0;
                rst      = 1'b1;
                eq_q.delete();
                er_q.delete();
                et_q.delete();
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_valid", out_valid, 0);
                chk("midrst_q", out_q, 0);
                chk("midrst_tag", out_tag, 0);
                repeat (12) @(negedge clk);

                random_phase(cfg_n(c));
                done = 1'b1;
            end
        end else if (c == 1) begin : g_drv_w13
            initial begin
                do_reset();
                mode = 0;
                send(13'd8191, 13'd1170, 3'd1);
                send(13'd6, 13'd0, 3'd6);
                wait_empty();
                random_phase(cfg_n(c));
                done = 1'b1;
            end
        end else begin : g_drv_rand
            initial begin
                do_reset();
                random_phase(cfg_n(c));
                done = 1'b1;
            end
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 90000 && !all_done; t++) begin
            @(negedge clk);
            all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done &&
                       g_cfg[3].done && g_cfg[4].done;
        end
        chk("all_done", all_done, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
